rs_ino_buf: RTL and testbench

In-order reservation-station storage driven by the allocation and issue controller of an in-order execution pipe. It writes up to two dispatched instructions per cycle at the allocation pointer and captures forwarded operands from result buses. It presents the oldest-entry read port at the issue pointer, frees entries on issue, and squashes mispredicted entries. Its `busyvec`, `readyvec` and `prbusyvec_next` outputs feed back into the allocator.

---
 rtl/rs_ino_buf_if.sv | 52 +++++
 rtl/rs_ino_buf.sv | 124 ++++++++++++
 tb/tb_rs_ino_buf.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_ino_buf_if.sv
// Port bundle between the in-order allocation/issue controller (master) and
// the reservation-station storage (slave).
interface rs_ino_buf_if #(
  parameter int ENTSEL      = 2,
  parameter int ENTNUM      = 4,
  parameter int DATALEN     = 32,
  parameter int RRFSEL      = 6,
  parameter int SPECTAG_LEN = 5,
  parameter int PLEN        = 32
);
  // Protocol: no backpressure. we1/we2 are single-cycle commands that must
  // target non-busy entries. fwd*_valid qualifies fwd*_tag/fwd*_data in the
  // same cycle only. issue_en frees issue_ptr at the clock edge, and the iss_*
  // read port always reflects issue_ptr.
  logic                   we1, we2;
  logic [ENTSEL-1:0]      waddr;
  logic [DATALEN-1:0]     src1_s1, src2_s1, src1_s2, src2_s2;
  logic                   src1v_s1, src2v_s1, src1v_s2, src2v_s2;
  logic [PLEN-1:0]        payload_s1, payload_s2;
  logic [SPECTAG_LEN-1:0] spectag_s1, spectag_s2;
  logic                   fwd1_valid, fwd2_valid;
  logic [RRFSEL-1:0]      fwd1_tag, fwd2_tag;
  logic [DATALEN-1:0]     fwd1_data, fwd2_data;
  logic                   issue_en;
  logic [ENTSEL-1:0]      issue_ptr;
  logic                   prmiss, prsuccess;
  logic [SPECTAG_LEN-1:0] prtag, killmask;
  logic [ENTNUM-1:0]      busyvec, readyvec, prbusyvec_next;
  logic [DATALEN-1:0]     iss_src1, iss_src2;
  logic [PLEN-1:0]        iss_payload;
  logic [SPECTAG_LEN-1:0] iss_spectag;

  modport master (
    output we1, we2, waddr, src1_s1, src2_s1, src1_s2, src2_s2,
           src1v_s1, src2v_s1, src1v_s2, src2v_s2, payload_s1, payload_s2,
           spectag_s1, spectag_s2, fwd1_valid, fwd2_valid, fwd1_tag, fwd2_tag,
           fwd1_data, fwd2_data, issue_en, issue_ptr, prmiss, prsuccess,
           prtag, killmask,
    input  busyvec, readyvec, prbusyvec_next, iss_src1, iss_src2,
           iss_payload, iss_spectag
  );

  modport slave (
    input  we1, we2, waddr, src1_s1, src2_s1, src1_s2, src2_s2,
           src1v_s1, src2v_s1, src1v_s2, src2v_s2, payload_s1, payload_s2,
           spectag_s1, spectag_s2, fwd1_valid, fwd2_valid, fwd1_tag, fwd2_tag,
           fwd1_data, fwd2_data, issue_en, issue_ptr, prmiss, prsuccess,
           prtag, killmask,
    output busyvec, readyvec, prbusyvec_next, iss_src1, iss_src2,
           iss_payload, iss_spectag
  );
endinterface

// File: rtl/rs_ino_buf.sv
// In-order reservation-station storage: dual-slot dispatch write, operand
// wakeup from two result buses, issue read port, and branch squash/resolve.
module rs_ino_buf #(
  parameter int ENTSEL      = 2,
  parameter int ENTNUM      = 4,
  parameter int DATALEN     = 32,
  parameter int RRFSEL      = 6,
  parameter int SPECTAG_LEN = 5,
  parameter int PLEN        = 32
) (
  input  logic        clk,
  input  logic        reset,
  rs_ino_buf_if.slave bus
);
  logic [ENTNUM-1:0]      busy, busy_n, src1v, src1v_n, src2v, src2v_n;
  logic [ENTNUM-1:0]      kill, iss_oh;
  logic [DATALEN-1:0]     src1 [ENTNUM];
  logic [DATALEN-1:0]     src1_n [ENTNUM];
  logic [DATALEN-1:0]     src2 [ENTNUM];
  logic [DATALEN-1:0]     src2_n [ENTNUM];
  logic [PLEN-1:0]        payload [ENTNUM];
  logic [PLEN-1:0]        payload_n [ENTNUM];
  logic [SPECTAG_LEN-1:0] spectag [ENTNUM];
  logic [SPECTAG_LEN-1:0] spectag_n [ENTNUM];
  logic [SPECTAG_LEN-1:0] spec_clr;
  logic [ENTSEL-1:0]      waddr2;
  logic [DATALEN:0]       w1_op1, w1_op2, w2_op1, w2_op2;

  // Returns {valid, data}; an invalid operand carries its rename tag in the
  // low RRFSEL bits, and fwd1 wins over fwd2 when both carry that tag.
  function automatic logic [DATALEN:0] capture(
    input logic v, input logic [DATALEN-1:0] d,
    input logic f1v, input logic [RRFSEL-1:0] f1t, input logic [DATALEN-1:0] f1d,
    input logic f2v, input logic [RRFSEL-1:0] f2t, input logic [DATALEN-1:0] f2d
  );
    logic [DATALEN:0] r;
    r = {v, d};
    if (!v) begin
      if (f1v && (d[RRFSEL-1:0] == f1t))      r = {1'b1, f1d};
      else if (f2v && (d[RRFSEL-1:0] == f2t)) r = {1'b1, f2d};
    end
    return r;
  endfunction

  assign waddr2 = bus.waddr + ENTSEL'(1);
  assign w1_op1 = capture(bus.src1v_s1, bus.src1_s1, bus.fwd1_valid, bus.fwd1_tag, bus.fwd1_data,
                          bus.fwd2_valid, bus.fwd2_tag, bus.fwd2_data);
  assign w1_op2 = capture(bus.src2v_s1, bus.src2_s1, bus.fwd1_valid, bus.fwd1_tag, bus.fwd1_data,
                          bus.fwd2_valid, bus.fwd2_tag, bus.fwd2_data);
  assign w2_op1 = capture(bus.src1v_s2, bus.src1_s2, bus.fwd1_valid, bus.fwd1_tag, bus.fwd1_data,
                          bus.fwd2_valid, bus.fwd2_tag, bus.fwd2_data);
  assign w2_op2 = capture(bus.src2v_s2, bus.src2_s2, bus.fwd1_valid, bus.fwd1_tag, bus.fwd1_data,
                          bus.fwd2_valid, bus.fwd2_tag, bus.fwd2_data);

  // A mispredict overrides a same-cycle resolve, so no tag bits are cleared then.
  always_comb begin
    spec_clr = (bus.prsuccess && !bus.prmiss) ? bus.prtag : '0;
    iss_oh   = '0;
    if (bus.issue_en) iss_oh[bus.issue_ptr] = 1'b1;
    for (int i = 0; i < ENTNUM; i++)
      kill[i] = bus.prmiss && busy[i] && (|(spectag[i] & bus.killmask));
  end

  always_comb begin
    busy_n = busy & ~kill & ~iss_oh;
    for (int i = 0; i < ENTNUM; i++) begin
      {src1v_n[i], src1_n[i]} = capture(src1v[i], src1[i], bus.fwd1_valid, bus.fwd1_tag,
                                        bus.fwd1_data, bus.fwd2_valid, bus.fwd2_tag, bus.fwd2_data);
      {src2v_n[i], src2_n[i]} = capture(src2v[i], src2[i], bus.fwd1_valid, bus.fwd1_tag,
                                        bus.fwd1_data, bus.fwd2_valid, bus.fwd2_tag, bus.fwd2_data);
      payload_n[i] = payload[i];
      spectag_n[i] = spectag[i] & ~spec_clr;
    end
    // Dispatch is dropped in a mispredict cycle; the allocator replays it.
    if (!bus.prmiss) begin
      if (bus.we1) begin
        busy_n[bus.waddr]                       = 1'b1;
        {src1v_n[bus.waddr], src1_n[bus.waddr]} = w1_op1;
        {src2v_n[bus.waddr], src2_n[bus.waddr]} = w1_op2;
        payload_n[bus.waddr]                    = bus.payload_s1;
        spectag_n[bus.waddr]                    = bus.spectag_s1 & ~spec_clr;
      end
      if (bus.we2) begin
        busy_n[waddr2]                  = 1'b1;
        {src1v_n[waddr2], src1_n[waddr2]} = w2_op1;
        {src2v_n[waddr2], src2_n[waddr2]} = w2_op2;
        payload_n[waddr2]               = bus.payload_s2;
        spectag_n[waddr2]               = bus.spectag_s2 & ~spec_clr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= '0;
      src1v <= '0;
      src2v <= '0;
      for (int i = 0; i < ENTNUM; i++) begin
        src1[i]    <= '0;
        src2[i]    <= '0;
        payload[i] <= '0;
        spectag[i] <= '0;
      end
    end else begin
      busy  <= busy_n;
      src1v <= src1v_n;
      src2v <= src2v_n;
      for (int i = 0; i < ENTNUM; i++) begin
        src1[i]    <= src1_n[i];
        src2[i]    <= src2_n[i];
        payload[i] <= payload_n[i];
        spectag[i] <= spectag_n[i];
      end
    end
  end

  assign bus.busyvec        = busy;
  assign bus.readyvec       = busy & src1v & src2v;
  assign bus.prbusyvec_next = busy & ~kill & ~iss_oh;
  assign bus.iss_src1       = src1[bus.issue_ptr];
  assign bus.iss_src2       = src2[bus.issue_ptr];
  assign bus.iss_payload    = payload[bus.issue_ptr];
  assign bus.iss_spectag    = spectag[bus.issue_ptr];
endmodule

// File: tb/tb_rs_ino_buf.sv
// Bench for rs_ino_buf: directed vector table, reset-priority sequence, then
// random traffic against an entry-level reference model.
module tb_rs_ino_buf;
  localparam int ENTSEL = 2, ENTNUM = 4, DATALEN = 32, RRFSEL = 6, SPECTAG_LEN = 5, PLEN = 32;
  localparam logic Y = 1'b1, N = 1'b0;
  localparam int NV = 26;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rs_ino_buf_if #(.ENTSEL(ENTSEL), .ENTNUM(ENTNUM), .DATALEN(DATALEN), .RRFSEL(RRFSEL),
                  .SPECTAG_LEN(SPECTAG_LEN), .PLEN(PLEN)) bus ();

  rs_ino_buf #(.ENTSEL(ENTSEL), .ENTNUM(ENTNUM), .DATALEN(DATALEN), .RRFSEL(RRFSEL),
               .SPECTAG_LEN(SPECTAG_LEN), .PLEN(PLEN)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    string       nm;
    logic        we1, we2;
    logic [1:0]  waddr;
    logic        v1, v2;
    logic [31:0] src2;
    logic [4:0]  sp1, sp2;
    logic        fv1;
    logic [5:0]  ft1;
    logic        fv2;
    logic [5:0]  ft2;
    logic        iss;
    logic [1:0]  iptr;
    logic        pm, ps;
    logic [4:0]  prtag, km;
    logic        chk;
    logic [31:0] e_src2, e_pay;
    logic [3:0]  e_prb, e_busy, e_ready;
  } vec_t;
  vec_t vt [NV];

  int n_chk = 0, n_fail = 0;

  // reference model: one record per entry
  logic        m_busy [4];
  logic        m_s1v [4], m_s2v [4];
  logic [31:0] m_s1 [4], m_s2 [4], m_pay [4];
  logic [4:0]  m_spec [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.we1 = 0; bus.we2 = 0; bus.waddr = '0;
    bus.src1_s1 = '0; bus.src2_s1 = '0; bus.src1_s2 = '0; bus.src2_s2 = '0;
    bus.src1v_s1 = 0; bus.src2v_s1 = 0; bus.src1v_s2 = 0; bus.src2v_s2 = 0;
    bus.payload_s1 = '0; bus.payload_s2 = '0; bus.spectag_s1 = '0; bus.spectag_s2 = '0;
    bus.fwd1_valid = 0; bus.fwd2_valid = 0; bus.fwd1_tag = '0; bus.fwd2_tag = '0;
    bus.fwd1_data = 32'h1111_1111; bus.fwd2_data = 32'hDEAD_BEEF;
    bus.issue_en = 0; bus.issue_ptr = '0;
    bus.prmiss = 0; bus.prsuccess = 0; bus.prtag = '0; bus.killmask = '0;
  endtask

  task automatic drive_vec(input vec_t v, input int idx);
    idle();
    bus.we1 = v.we1; bus.we2 = v.we2; bus.waddr = v.waddr;
    bus.src1_s1 = 32'h1234; bus.src1_s2 = 32'h1234;
    bus.src1v_s1 = v.v1; bus.src1v_s2 = v.v1;
    bus.src2_s1 = v.src2; bus.src2_s2 = v.src2;
    bus.src2v_s1 = v.v2; bus.src2v_s2 = v.v2;
    bus.payload_s1 = 32'hA000_0000 | 32'(idx);
    bus.payload_s2 = 32'hB000_0000 | 32'(idx);
    bus.spectag_s1 = v.sp1; bus.spectag_s2 = v.sp2;
    bus.fwd1_valid = v.fv1; bus.fwd1_tag = v.ft1;
    bus.fwd2_valid = v.fv2; bus.fwd2_tag = v.ft2;
    bus.issue_en = v.iss; bus.issue_ptr = v.iptr;
    bus.prmiss = v.pm; bus.prsuccess = v.ps; bus.prtag = v.prtag; bus.killmask = v.km;
  endtask

  function automatic logic [32:0] m_cap(input logic v, input logic [31:0] d);
    if (v) return {1'b1, d};
    if (bus.fwd1_valid && d[5:0] == bus.fwd1_tag) return {1'b1, bus.fwd1_data};
    if (bus.fwd2_valid && d[5:0] == bus.fwd2_tag) return {1'b1, bus.fwd2_data};
    return {1'b0, d};
  endfunction

  function automatic logic [3:0] m_busyvec();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_busy[i];
    return r;
  endfunction

  function automatic logic [3:0] m_readyvec();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_busy[i] && m_s1v[i] && m_s2v[i];
    return r;
  endfunction

  function automatic logic m_killed(input int i);
    return bus.prmiss && m_busy[i] && ((m_spec[i] & bus.killmask) != 0);
  endfunction

  function automatic logic [3:0] m_prb();
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = m_busy[i] && !m_killed(i) && !(bus.issue_en && int'(bus.issue_ptr) == i);
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 0; m_s1v[i] = 0; m_s2v[i] = 0;
      m_s1[i] = '0; m_s2[i] = '0; m_pay[i] = '0; m_spec[i] = '0;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic m_step();
    logic [3:0]  survive;
    logic [4:0]  clr;
    logic [1:0]  a2;
    logic [32:0] c;
    survive = m_prb();
    clr = (bus.prsuccess && !bus.prmiss) ? bus.prtag : 5'd0;
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = survive[i];
      c = m_cap(m_s1v[i], m_s1[i]); m_s1v[i] = c[32]; m_s1[i] = c[31:0];
      c = m_cap(m_s2v[i], m_s2[i]); m_s2v[i] = c[32]; m_s2[i] = c[31:0];
      m_spec[i] = m_spec[i] & ~clr;
    end
    a2 = bus.waddr + 2'd1;
    if (!bus.prmiss && bus.we1) begin
      m_busy[bus.waddr] = 1;
      c = m_cap(bus.src1v_s1, bus.src1_s1); m_s1v[bus.waddr] = c[32]; m_s1[bus.waddr] = c[31:0];
      c = m_cap(bus.src2v_s1, bus.src2_s1); m_s2v[bus.waddr] = c[32]; m_s2[bus.waddr] = c[31:0];
      m_pay[bus.waddr] = bus.payload_s1; m_spec[bus.waddr] = bus.spectag_s1 & ~clr;
    end
    if (!bus.prmiss && bus.we2) begin
      m_busy[a2] = 1;
      c = m_cap(bus.src1v_s2, bus.src1_s2); m_s1v[a2] = c[32]; m_s1[a2] = c[31:0];
      c = m_cap(bus.src2v_s2, bus.src2_s2); m_s2v[a2] = c[32]; m_s2[a2] = c[31:0];
      m_pay[a2] = bus.payload_s2; m_spec[a2] = bus.spectag_s2 & ~clr;
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    r[5:0] = 6'($urandom_range(0, 7));
    return r;
  endfunction

  task automatic rand_inputs();
    logic [1:0] a2;
    idle();
    bus.waddr = 2'($urandom_range(0, 3));
    a2 = bus.waddr + 2'd1;
    bus.we1 = ($urandom_range(0, 2) != 0) && !m_busy[bus.waddr];
    bus.we2 = ($urandom_range(0, 2) == 0) && !m_busy[a2];
    bus.src1_s1 = rnd_op(); bus.src2_s1 = rnd_op(); bus.src1_s2 = rnd_op(); bus.src2_s2 = rnd_op();
    bus.src1v_s1 = 1'($urandom_range(0, 1)); bus.src2v_s1 = 1'($urandom_range(0, 1));
    bus.src1v_s2 = 1'($urandom_range(0, 1)); bus.src2v_s2 = 1'($urandom_range(0, 1));
    bus.payload_s1 = $urandom; bus.payload_s2 = $urandom;
    bus.spectag_s1 = 5'($urandom); bus.spectag_s2 = 5'($urandom);
    bus.fwd1_valid = 1'($urandom_range(0, 1)); bus.fwd1_tag = 6'($urandom_range(0, 7));
    bus.fwd2_valid = 1'($urandom_range(0, 1)); bus.fwd2_tag = 6'($urandom_range(0, 7));
    bus.fwd1_data = $urandom; bus.fwd2_data = $urandom;
    bus.issue_ptr = 2'($urandom_range(0, 3));
    bus.issue_en = m_busy[bus.issue_ptr] && ($urandom_range(0, 1) == 1);
    bus.prmiss = ($urandom_range(0, 9) == 0);
    bus.killmask = 5'($urandom);
    bus.prsuccess = ($urandom_range(0, 5) == 0);
    bus.prtag = 5'(1 << $urandom_range(0, 4));
  endtask

  initial begin
    //        nm           we1 we2 wa    v1 v2 src2          sp1    sp2   fv1 ft1  fv2 ft2  iss ip    pm ps prtag  km     chk e_src2        e_pay          prb      busy     ready
    vt[0]  = '{"w1_e0",      Y, N, 2'd0, Y, Y, 32'h22,       5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, N, N, 5'd0,  5'd0,  N, 32'h0,        32'h0,         4'b0000, 4'b0001, 4'b0001};
    vt[1]  = '{"iss_e0",     N, N, 2'd0, Y, Y, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, Y, 2'd0, N, N, 5'd0,  5'd0,  Y, 32'h22,       32'hA000_0000, 4'b0000, 4'b0000, 4'b0000};
    vt[2]  = '{"dual_w3",    Y, Y, 2'd3, Y, Y, 32'h33,       5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, N, N, 5'd0,  5'd0,  N, 32'h0,        32'h0,         4'b0000, 4'b1001, 4'b1001};
    vt[3]  = '{"rd_pay3",    N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd3, N, N, 5'd0,  5'd0,  Y, 32'h33,       32'hA000_0002, 4'b1001, 4'b1001, 4'b1001};
    vt[4]  = '{"iss_e3",     N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, Y, 2'd3, N, N, 5'd0,  5'd0,  Y, 32'h33,       32'hA000_0002, 4'b0001, 4'b0001, 4'b0001};
    vt[5]  = '{"iss_e0_wrap",N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, Y, 2'd0, N, N, 5'd0,  5'd0,  Y, 32'h33,       32'hB000_0002, 4'b0000, 4'b0000, 4'b0000};
    vt[6]  = '{"w1_tag5",    Y, N, 2'd1, Y, N, 32'h5,        5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, N, N, 5'd0,  5'd0,  N, 32'h0,        32'h0,         4'b0000, 4'b0010, 4'b0000};
    vt[7]  = '{"fwd2_wake",  N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, Y, 6'd5, N, 2'd1, N, N, 5'd0,  5'd0,  Y, 32'h5,        32'hA000_0006, 4'b0010, 4'b0010, 4'b0010};
    vt[8]  = '{"wake_val",   N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd1, N, N, 5'd0,  5'd0,  Y, 32'hDEADBEEF, 32'hA000_0006, 4'b0010, 4'b0010, 4'b0010};
    vt[9]  = '{"iss_e1",     N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, Y, 2'd1, N, N, 5'd0,  5'd0,  Y, 32'hDEADBEEF, 32'hA000_0006, 4'b0000, 4'b0000, 4'b0000};
    vt[10] = '{"w_fwd_same", Y, N, 2'd2, Y, N, 32'h5,        5'd0,  5'd0, Y, 6'd5, Y, 6'd5, N, 2'd0, N, N, 5'd0,  5'd0,  N, 32'h0,        32'h0,         4'b0000, 4'b0100, 4'b0100};
    vt[11] = '{"fwd1_prio",  N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, Y, 2'd2, N, N, 5'd0,  5'd0,  Y, 32'h1111_1111, 32'hA000_000A, 4'b0000, 4'b0000, 4'b0000};
    vt[12] = '{"w_e0e1",     Y, Y, 2'd0, Y, Y, 32'h44,       5'd1,  5'd2, N, 6'd0, N, 6'd0, N, 2'd0, N, N, 5'd0,  5'd0,  N, 32'h0,        32'h0,         4'b0000, 4'b0011, 4'b0011};
    vt[13] = '{"w_e2",       Y, N, 2'd2, Y, Y, 32'h44,       5'd4,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, N, N, 5'd0,  5'd0,  N, 32'h0,        32'h0,         4'b0011, 4'b0111, 4'b0111};
    vt[14] = '{"pm_drop_w",  Y, N, 2'd3, Y, Y, 32'h44,       5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, Y, N, 5'd0,  5'd6,  N, 32'h0,        32'h0,         4'b0001, 4'b0001, 4'b0001};
    vt[15] = '{"iss_e0c",    N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, Y, 2'd0, N, N, 5'd0,  5'd0,  N, 32'h0,        32'h0,         4'b0000, 4'b0000, 4'b0000};
    vt[16] = '{"w_sp3",      Y, N, 2'd1, Y, Y, 32'h55,       5'd3,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, N, N, 5'd0,  5'd0,  N, 32'h0,        32'h0,         4'b0000, 4'b0010, 4'b0010};
    vt[17] = '{"prsucc",     N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, N, Y, 5'd2,  5'd0,  N, 32'h0,        32'h0,         4'b0010, 4'b0010, 4'b0010};
    vt[18] = '{"pm_k2_keep", N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, Y, N, 5'd0,  5'd2,  N, 32'h0,        32'h0,         4'b0010, 4'b0010, 4'b0010};
    vt[19] = '{"pm_k1_kill", N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, Y, N, 5'd0,  5'd1,  N, 32'h0,        32'h0,         4'b0000, 4'b0000, 4'b0000};
    vt[20] = '{"ps_write",   Y, N, 2'd2, Y, Y, 32'h66,       5'd6,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, N, Y, 5'd4,  5'd0,  N, 32'h0,        32'h0,         4'b0000, 4'b0100, 4'b0100};
    vt[21] = '{"pm_k4_keep", N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, Y, N, 5'd0,  5'd4,  N, 32'h0,        32'h0,         4'b0100, 4'b0100, 4'b0100};
    vt[22] = '{"pm_k2_kill", N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, Y, N, 5'd0,  5'd2,  N, 32'h0,        32'h0,         4'b0000, 4'b0000, 4'b0000};
    vt[23] = '{"w_sp2",      Y, N, 2'd3, Y, Y, 32'h77,       5'd2,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, N, N, 5'd0,  5'd0,  N, 32'h0,        32'h0,         4'b0000, 4'b1000, 4'b1000};
    vt[24] = '{"pm_ps_both", N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, Y, Y, 5'd2,  5'd1,  N, 32'h0,        32'h0,         4'b1000, 4'b1000, 4'b1000};
    vt[25] = '{"pm_k2_late", N, N, 2'd0, N, N, 32'h0,        5'd0,  5'd0, N, 6'd0, N, 6'd0, N, 2'd0, Y, N, 5'd0,  5'd2,  N, 32'h0,        32'h0,         4'b0000, 4'b0000, 4'b0000};

    // clock/reset
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("reset_busy", bus.busyvec, 4'b0000);
    chk("reset_ready", bus.readyvec, 4'b0000);
    chk("reset_prb", bus.prbusyvec_next, 4'b0000);
    chk("reset_spectag", bus.iss_spectag, 5'd0);

    // directed vector table
    for (int i = 0; i < NV; i++) begin
      drive_vec(vt[i], i);
      #1;
      chk({vt[i].nm, ".prb"}, bus.prbusyvec_next, vt[i].e_prb);
      if (vt[i].chk) begin
        chk({vt[i].nm, ".iss_src2"}, bus.iss_src2, vt[i].e_src2);
        chk({vt[i].nm, ".iss_payload"}, bus.iss_payload, vt[i].e_pay);
      end
      @(posedge clk);
      #1;
      chk({vt[i].nm, ".busy"}, bus.busyvec, vt[i].e_busy);
      chk({vt[i].nm, ".ready"}, bus.readyvec, vt[i].e_ready);
    end

    // reset while every entry is busy, a wakeup is pending and a squash is active
    idle();
    bus.we1 = 1; bus.we2 = 1; bus.waddr = 2'd0;
    bus.src1v_s1 = 1; bus.src1v_s2 = 1; bus.src2_s1 = 32'h7; bus.src2_s2 = 32'h7;
    bus.spectag_s1 = 5'd1; bus.spectag_s2 = 5'd1;
    @(posedge clk);
    #1;
    bus.waddr = 2'd2;
    @(posedge clk);
    #1;
    chk("rst_pre_busy", bus.busyvec, 4'b1111);
    chk("rst_pre_ready", bus.readyvec, 4'b0000);
    idle();
    reset = 1;
    bus.fwd2_valid = 1; bus.fwd2_tag = 6'd7;
    bus.prmiss = 1; bus.killmask = 5'd1;
    @(posedge clk);
    #1;
    reset = 0;
    idle();
    #1;
    chk("rst_busy", bus.busyvec, 4'b0000);
    chk("rst_ready", bus.readyvec, 4'b0000);
    chk("rst_prb", bus.prbusyvec_next, 4'b0000);
    chk("rst_spectag", bus.iss_spectag, 5'd0);

    // random traffic against the model
    m_reset();
    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      #1;
      chk("rnd_prb", bus.prbusyvec_next, m_prb());
      if (m_busy[bus.issue_ptr]) begin
        chk("rnd_iss_src1", bus.iss_src1, m_s1[bus.issue_ptr]);
        chk("rnd_iss_src2", bus.iss_src2, m_s2[bus.issue_ptr]);
        chk("rnd_iss_payload", bus.iss_payload, m_pay[bus.issue_ptr]);
        chk("rnd_iss_spectag", bus.iss_spectag, m_spec[bus.issue_ptr]);
      end
      m_step();
      @(posedge clk);
      #1;
      chk("rnd_busy", bus.busyvec, m_busyvec());
      chk("rnd_ready", bus.readyvec, m_readyvec());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
